// File: rtl/seldemux_buf.sv
// One-entry selection demultiplexer: a single word fanned out to none, A, B or both.
// Latency: one cycle from accept to a_valid/b_valid; dropped words are counted, not held.
// Backpressure: in_ready is low while a routed word is pending; A and B drain independently.
module seldemux_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             sa,
  input  logic             sb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] qa,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] qb,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             pa;
  logic             pa_nxt;
  logic             pb;
  logic             pb_nxt;
  logic [WIDTH-1:0] data_r;
  logic [7:0]       drop_r;
  logic             accept;
  logic             drop;

  // Ready comes straight from the state register so upstream never sees a
  // combinational path through this block.
  assign in_ready = (state == EMPTY);
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~sa & ~sb;

  // Both destinations see the same held word; the pending flags say who still wants it.
  assign qa       = data_r;
  assign qb       = data_r;
  assign a_valid  = pa;
  assign b_valid  = pb;
  assign drop_cnt = drop_r;

  // Next-state and pending-flag logic. A HOLD with no pending flag left
  // (including any illegal encoding) always falls back to EMPTY.
  always_comb begin
    state_nxt = state;
    pa_nxt    = pa;
    pb_nxt    = pb;
    case (state)
      EMPTY: begin
        pa_nxt = 1'b0;
        pb_nxt = 1'b0;
        if (accept) begin
          pa_nxt = sa;
          pb_nxt = sb;
          if (sa | sb) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (pa && a_ready) begin
          pa_nxt = 1'b0;
        end
        if (pb && b_ready) begin
          pb_nxt = 1'b0;
        end
        if (!pa_nxt && !pb_nxt) begin
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  // State and pending flags; reset abandons any pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      pa    <= 1'b0;
      pb    <= 1'b0;
    end else begin
      state <= state_nxt;
      pa    <= pa_nxt;
      pb    <= pb_nxt;
    end
  end

  // Data register loads only on accept, which can only happen in EMPTY,
  // so the word is frozen for the whole HOLD period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if (accept) begin
      data_r <= d;
    end
  end

  // Saturating count of words accepted with no destination selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 8'd0;
    end else if (drop && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_seldemux_buf.sv
// Bench for seldemux_buf: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the buffer.
module tb_seldemux_buf;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             sa;
  logic             sb;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] qa;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] qb;
  logic             b_valid;
  logic             b_ready;
  logic [7:0]       drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the held word and the set of destinations still owed it.
  logic [WIDTH-1:0] m_word;
  logic             m_owe_a;
  logic             m_owe_b;
  int               m_drops;

  always #5 clk = ~clk;

  seldemux_buf #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .sa       (sa),
    .sb       (sb),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .qa       (qa),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .qb       (qb),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic busy;
    busy = m_owe_a | m_owe_b;
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ~busy});
    check({tag, ".a_valid"},  {31'd0, a_valid},  {31'd0, m_owe_a});
    check({tag, ".b_valid"},  {31'd0, b_valid},  {31'd0, m_owe_b});
    check({tag, ".qa"},       {24'd0, qa},       {24'd0, m_word});
    check({tag, ".qb"},       {24'd0, qb},       {24'd0, m_word});
    check({tag, ".drop_cnt"}, {24'd0, drop_cnt}, m_drops);
  endtask

  task automatic model_reset();
    m_word  = '0;
    m_owe_a = 1'b0;
    m_owe_b = 1'b0;
    m_drops = 0;
  endtask

  // Advance the model by one edge using the inputs currently driven, clock
  // the DUT, then compare just after the edge.
  task automatic cycle(input string tag);
    if (m_owe_a || m_owe_b) begin
      if (a_ready) m_owe_a = 1'b0;
      if (b_ready) m_owe_b = 1'b0;
    end else if (in_valid) begin
      m_word  = d;
      m_owe_a = sa;
      m_owe_b = sb;
      if (!sa && !sb) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] dd, input logic s_a,
                       input logic s_b, input logic ra, input logic rb);
    in_valid = v;
    d        = dd;
    sa       = s_a;
    sb       = s_b;
    a_ready  = ra;
    b_ready  = rb;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    #1;

    // Route to A.
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("routeA.acc");
    check("routeA.qa_const", {24'd0, qa}, 32'h5A);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("routeA.drain");

    // Broadcast with B draining first.
    drive(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("bcast.acc");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("bcast.drainB");
    check("bcast.a_still", {31'd0, a_valid}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("bcast.drainA");

    // Broadcast drained on a single edge.
    drive(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("simul.acc");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("simul.drain");
    check("simul.ready_const", {31'd0, in_ready}, 32'd1);

    // Ready ignored while nothing is owed to that destination.
    drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("ignore.acc");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("ignore.a_ready");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("ignore.drainB");

    // Backpressure: offered words are not taken while holding.
    drive(1'b1, 8'h17, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("bp.acc");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("bp.hold");
    end
    check("bp.qa_const", {24'd0, qa}, 32'h17);
    drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("bp.drain");
    drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("bp.next_acc");
    check("bp.qa_new", {24'd0, qa}, 32'hFF);

    // Asynchronous reset in the middle of a HOLD.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst.mid");
    #1;
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("arst.after");

    // Drops on consecutive edges, saturating.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'($urandom), 1'($urandom));
      cycle("drop");
    end
    check("drop.sat_const", {24'd0, drop_cnt}, 32'd255);

    // Random traffic; reset first so drop_cnt is exercised below saturation too.
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
